// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single byte-wide RAM/IO port among N_CH requesters. Each
//   requester posts one 1-, 2- or 4-byte little-endian read or write. The
//   winning request is serialised one byte per cycle onto mem_a/mem_dout/mem_wr.
//   Read bytes return one cycle after issue and are assembled into rdata.
//   Completion is signalled by a one-cycle done pulse.
//
//   Build option: define MEM_ARB_RR_EN for round-robin arbitration. When it is
//   undefined, fixed priority is used and channel 0 has the highest priority.
//
// Ports
//   clk_in, rst_n_in     clock, asynchronous active-low reset
//   rdy_in               global ready; low freezes all state
//   req_valid/req_wr     per-channel request and write flag
//   req_size             2 bits per channel: 0=1B, 1=2B, 2/3=4B
//   req_addr/req_wdata   per-channel start address and write data
//   flush_in             per-channel read abort
//   done, rdata          completion pulse and zero-extended read data
//   busy                 a transfer is in progress
//   mem_din/mem_dout     RAM/IO read byte / write byte
//   mem_a, mem_wr        byte address and write strobe
//   io_buffer_full       IO sink cannot accept a write this cycle
module mem_arbiter #(
   parameter int N_CH   = 2,
   parameter int ADDR_W = 32   // must be >= 18 so the IO window bits exist
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   rdy_in,
   input  logic [N_CH-1:0]        req_valid,
   input  logic [N_CH-1:0]        req_wr,
   input  logic [2*N_CH-1:0]      req_size,
   input  logic [ADDR_W*N_CH-1:0] req_addr,
   input  logic [32*N_CH-1:0]     req_wdata,
   input  logic [N_CH-1:0]        flush_in,
   output logic [N_CH-1:0]        done,
   output logic [31:0]            rdata,
   output logic                   busy,
   input  logic [7:0]             mem_din,
   output logic [7:0]             mem_dout,
   output logic [ADDR_W-1:0]      mem_a,
   output logic                   mem_wr,
   input  logic                   io_buffer_full
);

   localparam int IDX_W = $clog2(N_CH);

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  owner;
   logic [ADDR_W-1:0] base_addr;
   logic [31:0]       wdata_q;
   logic [2:0]        len;        // transfer length in bytes: 1, 2 or 4
   logic [2:0]        cnt;        // bytes issued so far
   logic [ADDR_W-1:0] byte_addr;
   logic [7:0]        wr_byte;
   logic [1:0]        cap_lane;   // lane of the byte issued last cycle
   logic              io_stall;
   logic              complete;
   logic              abort;

   logic [N_CH-1:0]   eligible;
   logic              grant_any;
   logic [IDX_W-1:0]  grant_idx;

   // Per-channel views of the flattened request buses.
   logic [1:0]        size_ch  [N_CH];
   logic [ADDR_W-1:0] addr_ch  [N_CH];
   logic [31:0]       wdata_ch [N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_unpack
      assign size_ch[i]  = req_size[2*i +: 2];
      assign addr_ch[i]  = req_addr[ADDR_W*i +: ADDR_W];
      assign wdata_ch[i] = req_wdata[32*i +: 32];
   end

   function automatic logic [2:0] size_to_len(input logic [1:0] size);
      case (size)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;   // reserved encoding behaves as 4 bytes
      endcase
   endfunction

   // A channel finishing this cycle sits out one arbitration round.
   assign eligible  = req_valid & ~flush_in & ~done;
   assign byte_addr = base_addr + ADDR_W'(cnt);   // wraps modulo 2^ADDR_W
   assign wr_byte   = wdata_q[{cnt[1:0], 3'b000} +: 8];
   assign cap_lane  = cnt[1:0] - 2'd1;
   assign io_stall  = (state == WR) && (byte_addr[17:16] == 2'b11) && io_buffer_full;

`ifdef MEM_ARB_RR_EN
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int off = 0; off < N_CH; off++) begin
         cand = IDX_W'((int'(last_grant) + 1 + off) % N_CH);
         if (!grant_any && eligible[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         last_grant <= IDX_W'(N_CH - 1);
      else if (rdy_in && (state == IDLE) && grant_any)
         last_grant <= grant_idx;
   end
`else
   // NOTE: every variable driven here gets a default first so no path infers a latch.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      // Scan downward so the lowest eligible index is the last one written.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            grant_any = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
   end
`endif

   // State register
   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         state <= IDLE;
      else if (rdy_in)
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      complete  = 1'b0;
      abort     = 1'b0;
      unique case (state)
         IDLE: if (grant_any) state_nxt = req_wr[grant_idx] ? WR : RD;
         RD: begin
            if (flush_in[owner]) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == len) begin
               // The final cycle issues nothing; it only captures the last byte.
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         WR: begin
            if (!io_stall && (cnt == len - 3'd1)) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bus outputs. They are decoded from frozen state, so a paused bus holds
   // its address, while the write strobe is qualified by rdy_in.
   always_comb begin
      mem_a    = '0;
      mem_dout = '0;
      mem_wr   = 1'b0;
      busy     = (state != IDLE);
      unique case (state)
         RD: if (cnt < len) mem_a = byte_addr;
         WR: begin
            if (!io_stall) begin
               mem_a    = byte_addr;
               mem_dout = wr_byte;
               mem_wr   = rdy_in;
            end
         end
         default: ;
      endcase
   end

   // Request latch, byte counter, read assembly and completion pulse.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         owner     <= '0;
         base_addr <= '0;
         wdata_q   <= '0;
         len       <= 3'd1;
         cnt       <= '0;
         done      <= '0;
         rdata     <= '0;
      end else if (rdy_in) begin
         done <= '0;
         unique case (state)
            IDLE: begin
               if (grant_any) begin
                  owner     <= grant_idx;
                  base_addr <= addr_ch[grant_idx];
                  wdata_q   <= wdata_ch[grant_idx];
                  len       <= size_to_len(size_ch[grant_idx]);
                  cnt       <= '0;
                  rdata     <= '0;
               end
            end
            RD: begin
               if (abort) begin
                  rdata <= '0;
               end else begin
                  if (cnt != 3'd0) rdata[{cap_lane, 3'b000} +: 8] <= mem_din;
                  if (!complete) cnt <= cnt + 3'd1;
               end
            end
            WR: if (!io_stall) cnt <= cnt + 3'd1;
            default: ;
         endcase
         if (complete) done[owner] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A transaction-level model expands each grant into a
// queue of expected bus bytes and checks the DUT every cycle. Directed tests
// add literal checks at fixed cycle offsets from the grant cycle.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int N_CH   = 2;
   localparam int ADDR_W = 32;

   logic                   clk_in = 1'b0;
   logic                   rst_n_in = 1'b1;
   logic                   rdy_in = 1'b1;
   logic [N_CH-1:0]        req_valid = '0;
   logic [N_CH-1:0]        req_wr = '0;
   logic [2*N_CH-1:0]      req_size = '0;
   logic [ADDR_W*N_CH-1:0] req_addr = '0;
   logic [32*N_CH-1:0]     req_wdata = '0;
   logic [N_CH-1:0]        flush_in = '0;
   logic [N_CH-1:0]        done;
   logic [31:0]            rdata;
   logic                   busy;
   logic [7:0]             mem_din;
   logic [7:0]             mem_dout;
   logic [ADDR_W-1:0]      mem_a;
   logic                   mem_wr;
   logic                   io_buffer_full = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   mem_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata), .flush_in(flush_in),
      .done(done), .rdata(rdata), .busy(busy),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk_in = ~clk_in;

   // Read-only memory contents: 0x100..0x103 hold 11,22,33,44.
   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      logic [7:0] lane;
      lane = {6'd0, a[1:0]} + 8'd1;
      return (lane * 8'h11) + {a[7:2], 2'b00};
   endfunction

   // Memory answers one cycle after the address; held while paused.
   logic [ADDR_W-1:0] lat_a = '0;
   always @(posedge clk_in) if (rdy_in) lat_a <= mem_a;
   assign mem_din = rd_byte(lat_a);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction model ----------------
   typedef struct packed { logic [31:0] a; logic [7:0] d; } wbyte_t;

   logic [31:0]     rd_q [$];
   wbyte_t          wr_q [$];
   bit              m_active = 1'b0;
   bit              m_wr = 1'b0;
   bit              m_last_rd = 1'b0;
   int              m_ch = 0;
   int              m_last = N_CH - 1;
   logic [N_CH-1:0] m_done = '0;
   logic [31:0]     m_rdata = '0;
   logic [31:0]     m_rexp = '0;
   logic [N_CH-1:0] mt_elig;
   int              mt_pick;
   int              mt_n;
   logic [31:0]     mt_a;
   logic [31:0]     mt_d;
   wbyte_t          mt_w;

   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         m_active = 1'b0;
         m_done   = '0;
         m_last   = N_CH - 1;
         rd_q.delete();
         wr_q.delete();
      end else if (rdy_in) begin
         mt_elig = req_valid & ~flush_in & ~m_done;
         m_done  = '0;
         if (m_active && !m_wr) begin
            if (flush_in[m_ch]) begin
               m_active = 1'b0;
               rd_q.delete();
            end else if (rd_q.size() > 0) begin
               void'(rd_q.pop_front());
            end else begin
               m_active     = 1'b0;
               m_done[m_ch] = 1'b1;
               m_rdata      = m_rexp;
               m_last_rd    = 1'b1;
            end
         end else if (m_active) begin
            if (!(wr_q[0].a[17:16] == 2'b11 && io_buffer_full)) begin
               void'(wr_q.pop_front());
               if (wr_q.size() == 0) begin
                  m_active     = 1'b0;
                  m_done[m_ch] = 1'b1;
                  m_last_rd    = 1'b0;
               end
            end
         end else begin
            mt_pick = -1;
`ifdef MEM_ARB_RR_EN
            for (int off = 1; off <= N_CH; off++)
               if (mt_pick < 0 && mt_elig[(m_last + off) % N_CH]) mt_pick = (m_last + off) % N_CH;
`else
            for (int i = 0; i < N_CH; i++)
               if (mt_pick < 0 && mt_elig[i]) mt_pick = i;
`endif
            if (mt_pick >= 0) begin
               m_ch   = mt_pick;
               m_last = mt_pick;
               m_wr   = req_wr[m_ch];
               mt_n   = (req_size[2*m_ch +: 2] == 2'd0) ? 1 : (req_size[2*m_ch +: 2] == 2'd1) ? 2 : 4;
               mt_a   = req_addr[ADDR_W*m_ch +: ADDR_W];
               mt_d   = req_wdata[32*m_ch +: 32];
               m_rexp = '0;
               for (int k = 0; k < mt_n; k++) begin
                  if (m_wr) begin
                     mt_w.a = mt_a + 32'(k);
                     mt_w.d = mt_d[8*k +: 8];
                     wr_q.push_back(mt_w);
                  end else begin
                     rd_q.push_back(mt_a + 32'(k));
                     m_rexp = m_rexp | (32'(rd_byte(mt_a + 32'(k))) << (8*k));
                  end
               end
               m_active = 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [31:0] e_a;
   logic [7:0]  e_d;
   logic        e_w;

   always @(negedge clk_in) begin
      if (rst_n_in) begin
         e_a = '0;
         e_d = '0;
         e_w = 1'b0;
         if (m_active && !m_wr && rd_q.size() > 0) begin
            e_a = rd_q[0];
         end else if (m_active && m_wr) begin
            if (!(wr_q[0].a[17:16] == 2'b11 && io_buffer_full)) begin
               e_a = wr_q[0].a;
               e_d = wr_q[0].d;
               e_w = rdy_in;
            end
         end
         check("cmp_busy", busy, m_active);
         check("cmp_mem_a", mem_a, e_a);
         check("cmp_mem_wr", mem_wr, e_w);
         if (e_w || !m_active) check("cmp_mem_dout", mem_dout, e_d);
         check("cmp_done", done, m_done);
         if (m_done != '0 && m_last_rd) check("cmp_rdata", rdata, m_rdata);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_req(input int ch, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wd);
      req_wr[ch]                  = wr;
      req_size[2*ch +: 2]         = size;
      req_addr[ADDR_W*ch +: ADDR_W] = addr;
      req_wdata[32*ch +: 32]      = wd;
      req_valid[ch]               = 1'b1;
   endtask

   int order [$];
   int dcnt [N_CH];
   int exp_order [4] = '{0, 1, 0, 1};

   initial begin
      #1 rst_n_in = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 2'b00);
      check("rst_rdata", rdata, 32'h0);
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_mem_wr", mem_wr, 1'b0);
      check("rst_mem_dout", mem_dout, 8'h00);
      @(posedge clk_in);
      @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      tick();

      // Ch0 4-byte read at 0x100.
      set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk_in);
         case (c)
            0: check("t1_idle_busy", busy, 1'b0);
            1: check("t1_a0", mem_a, 32'h100);
            4: check("t1_a3", mem_a, 32'h103);
            5: check("t1_no_done_yet", done, 2'b00);
            6: begin
               check("t1_done", done, 2'b01);
               check("t1_rdata", rdata, 32'h44332211);
            end
            default: ;
         endcase
         tick();
      end
      req_valid[0] = 1'b0;
      tick();

      // Ch1 2-byte write across the 0x1FFFF boundary.
      set_req(1, 1'b1, 2'd1, 32'h0001_FFFF, 32'h0000_BEEF);
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk_in);
         case (c)
            1: begin
               check("t2_a0", mem_a, 32'h0001_FFFF);
               check("t2_d0", mem_dout, 8'hEF);
               check("t2_wr0", mem_wr, 1'b1);
            end
            2: begin
               check("t2_a1", mem_a, 32'h0002_0000);
               check("t2_d1", mem_dout, 8'hBE);
            end
            3: begin
               check("t2_done", done, 2'b10);
               check("t2_wr_off", mem_wr, 1'b0);
            end
            default: ;
         endcase
         tick();
      end
      req_valid[1] = 1'b0;
      tick();

      // IO write stalled by a full buffer for three cycles.
      set_req(0, 1'b1, 2'd0, 32'h0003_0000, 32'h41);
      for (int c = 0; c <= 5; c++) begin
         io_buffer_full = (c >= 1 && c <= 3);
         @(negedge clk_in);
         case (c)
            1, 2, 3: check("t3_stall_wr", mem_wr, 1'b0);
            4: begin
               check("t3_wr", mem_wr, 1'b1);
               check("t3_dout", mem_dout, 8'h41);
               check("t3_a", mem_a, 32'h0003_0000);
            end
            5: check("t3_done", done, 2'b01);
            default: ;
         endcase
         tick();
      end
      req_valid[0] = 1'b0;
      tick();

      // Flush of a ch0 read; ch1 is granted in the abort's IDLE cycle.
      set_req(0, 1'b0, 2'd2, 32'h200, 32'h0);
      for (int c = 0; c <= 6; c++) begin
         if (c == 1) set_req(1, 1'b0, 2'd0, 32'h300, 32'h0);
         if (c == 2 || c == 3) flush_in[0] = 1'b1;
         if (c == 4) begin
            flush_in[0]  = 1'b0;
            req_valid[0] = 1'b0;
         end
         @(negedge clk_in);
         case (c)
            2: check("t4_a1", mem_a, 32'h201);
            3: begin
               check("t4_idle", busy, 1'b0);
               check("t4_no_done", done, 2'b00);
            end
            4: begin
               check("t4_ch1_busy", busy, 1'b1);
               check("t4_ch1_a", mem_a, 32'h300);
            end
            6: begin
               check("t4_done1", done, 2'b10);
               check("t4_rdata", rdata, 32'h11);
            end
            default: ;
         endcase
         tick();
      end
      req_valid[1] = 1'b0;
      tick();

      // Both channels request 1-byte reads continuously.
      set_req(0, 1'b0, 2'd0, 32'h400, 32'h0);
      set_req(1, 1'b0, 2'd0, 32'h501, 32'h0);
      for (int i = 0; i < N_CH; i++) dcnt[i] = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_in);
         for (int i = 0; i < N_CH; i++)
            if (done[i]) begin
               order.push_back(i);
               dcnt[i]++;
            end
         tick();
         for (int i = 0; i < N_CH; i++) req_valid[i] = (dcnt[i] < 2);
         if (order.size() >= 4) break;
      end
      req_valid = '0;
      check("t5_count", order.size(), 4);
      if (order.size() == 4)
         for (int k = 0; k < 4; k++) check($sformatf("t5_order%0d", k), order[k], exp_order[k]);
      tick();

      // Pause during a write and during its done pulse.
      set_req(0, 1'b1, 2'd0, 32'h55, 32'h7E);
      for (int c = 0; c <= 7; c++) begin
         rdy_in = !(c == 1 || c == 2 || c == 4 || c == 5);
         if (c == 5) req_valid[0] = 1'b0;
         @(negedge clk_in);
         case (c)
            1: begin
               check("t6_hold_a", mem_a, 32'h55);
               check("t6_hold_wr", mem_wr, 1'b0);
            end
            2: check("t6_hold_busy", busy, 1'b1);
            3: begin
               check("t6_wr", mem_wr, 1'b1);
               check("t6_dout", mem_dout, 8'h7E);
            end
            5: check("t6_done_ext", done, 2'b01);
            6: check("t6_done_last", done, 2'b01);
            7: check("t6_done_clr", done, 2'b00);
            default: ;
         endcase
         tick();
      end
      rdy_in = 1'b1;
      tick();

      // Asynchronous reset in the middle of a 4-byte write.
      set_req(1, 1'b1, 2'd2, 32'h1000, 32'hCAFE_BABE);
      @(negedge clk_in);
      tick();
      @(negedge clk_in);
      check("t7_pre_a", mem_a, 32'h1000);
      tick();
      rst_n_in = 1'b0;
      #1;
      check("t7_rst_wr", mem_wr, 1'b0);
      check("t7_rst_a", mem_a, 32'h0);
      check("t7_rst_busy", busy, 1'b0);
      check("t7_rst_dout", mem_dout, 8'h00);
      req_valid = '0;
      tick();
      rst_n_in = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_in);
         check("t7_no_done", done, 2'b00);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial memory arbiter that shares the single 8-bit RAM/IO port among N_CH requesters (instruction fetch, load/store buffer, future prefetch/DMA). Each channel posts one 1/2/4-byte little-endian read or write. The arbiter serialises it onto mem_a/mem_dout/mem_wr, honours the 1-cycle read latency and io_buffer_full, and returns read data with a one-cycle done pulse. It replaces the ad-hoc IF/SLB muxing in the CPU top and adds per-channel flush, multi-byte assembly and selectable arbitration.

## Interface
- N_CH, 2, number of requesting channels (>=2); channel 0 is highest fixed priority
- ADDR_W, 32, address width
- clk_in  in  1  clock
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low freezes the block
- req_valid  in  N_CH  per-channel request; held high until that channel's done
- req_wr  in  N_CH  1 = write
- req_size  in  2*N_CH  0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = reserved (treated as 4 B)
- req_addr  in  ADDR_W*N_CH  start byte address
- req_wdata  in  32*N_CH  write data, byte 0 = bits [7:0]
- flush_in  in  N_CH  abort the channel's read (control hazard)
- done  out  N_CH  one-cycle completion pulse
- rdata  out  32  read data, valid while any done bit is high; zero-extended
- busy  out  1  a transfer is owned
- mem_din  in  8  RAM/IO read byte
- mem_dout  out  8  write byte
- mem_a  out  ADDR_W  byte address
- mem_wr  out  1  write strobe
- io_buffer_full  in  1  UART TX buffer full

## Operation
- States: IDLE, RD, WR.
- IDLE:
  - Eligible = req_valid & ~flush_in & ~done.
  - If any channel is eligible, pick a winner and latch its wr/size/addr/wdata. Count n = 1/2/4. Go to RD or WR.
- RD:
  - Byte k (k = 0..n-1) is issued on consecutive cycles with mem_a = addr+k (mod 2^ADDR_W), mem_wr = 0.
  - Byte k is captured from mem_din in the cycle after it is issued and placed in rdata[8k+7:8k].
  - After the last capture, pulse done[owner] and return to IDLE.
- WR:
  - Byte k drives mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr = 1.
  - IO address (addr[17:16] == 2'b11) with io_buffer_full high: no issue that cycle (mem_a = 0, mem_wr = 0); k holds until the buffer frees.
  - After the last byte, pulse done and return to IDLE.
- Flush:
  - flush_in[owner] during RD aborts at the next edge: go to IDLE, no done, captured bytes discarded.
  - flush_in is ignored during WR; writes always complete.
  - A flushed channel is not granted in that cycle.
- Idle bus: mem_a = 0, mem_wr = 0, mem_dout = 0.
- rdy_in low: no state, counter, capture or done change; mem_wr forced 0; mem_a held. The environment holds mem_din stable while paused. done pulses extend until the next ready cycle.
- Reset: state IDLE; done, rdata, mem_a, mem_dout, mem_wr, busy all 0; round-robin pointer = N_CH-1.

## Timing
- Grant cycle G is the IDLE cycle that samples the request.
- Read of n bytes:
  - Addresses on G+1 … G+n.
  - Last capture at G+n+1.
  - done at G+n+2.
  - 1-byte read: done at G+3.
- Write of n bytes: bytes on G+1 … G+n; done at G+n+1, absent IO stalls. Each stalled cycle adds one.
- done cycle is an IDLE cycle. A different channel may be granted in it. The completing channel is excluded for that one cycle only.
- busy = (state != IDLE).

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. Search starts at (last_grant+1) mod N_CH; last_grant updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register.

## Test plan
- Ch0 4-byte read at 0x00000100, RAM bytes 11,22,33,44:
  - mem_a = 0x100..0x103 on G+1..G+4.
  - done[0] at G+6.
  - rdata = 0x44332211.
- Ch1 2-byte write 0xBEEF at 0x0001FFFF: mem_a 0x1FFFF then 0x20000, mem_dout EF then BE, mem_wr high 2 cycles, done[1] at G+3.
- IO 1-byte write 0x41 at 0x30000 with io_buffer_full high 3 cycles then low: mem_wr stays 0 for 3 cycles, then a single write of 0x41, then done.
- Ch0 4-byte read with flush_in[0] on G+2: IDLE at G+3, no done[0]. A pending ch1 request is granted in that IDLE cycle.
- Both channels request continuously, 1-byte reads:
  - MEM_ARB_RR_EN: grants alternate 0,1,0,1.
  - Without it: ch0 always wins except in its own done cycle, where ch1 is granted.
- rst_n_in low mid-write (G+2): outputs 0 immediately, asynchronously. After release, state is IDLE and no done fires.
